// File: rtl/ins_dispatch_pkg.sv
// Instruction-format constants shared by the dispatcher and its queues.
// Word layout from the MSB: type[2], opcode[4], buf_id/pe_id[BUF_ID_W], then unit-specific payload.
package ins_dispatch_pkg;

    localparam int TYPE_W = 2;
    localparam int OP_W   = 4;
    localparam int CFG_W  = 30;

    typedef enum logic [1:0] {
        TY_LOAD = 2'b00,
        TY_CALC = 2'b01,
        TY_SAVE = 2'b10,
        TY_CFG  = 2'b11
    } ins_type_e;

    typedef enum logic [1:0] {
        S_RUN   = 2'b00,
        S_DRAIN = 2'b01,
        S_ERR   = 2'b10
    } state_e;

    localparam logic [3:0] RD_OP_IMG   = 4'b0000;
    localparam logic [3:0] RD_OP_WGT   = 4'b0001;
    localparam logic [3:0] RD_OP_BIAS  = 4'b0100;
    localparam logic [3:0] RD_OP_SCALE = 4'b0101;
    localparam logic [3:0] RD_OP_POOL  = 4'b0110;
    localparam logic [3:0] RD_OP_TBL   = 4'b0111;

    localparam logic [3:0] WR_OP_IMG   = 4'b0000;
    localparam logic [3:0] WR_OP_RES0  = 4'b1000;
    localparam logic [3:0] WR_OP_RES1  = 4'b1001;
    localparam logic [3:0] WR_OP_RES2  = 4'b1010;
    localparam logic [3:0] WR_OP_RES3  = 4'b1011;

    localparam logic [3:0] LT_CONV = 4'b0000;
    localparam logic [3:0] LT_FC   = 4'b0001;
    localparam logic [3:0] LT_POOL = 4'b0010;
    localparam logic [3:0] LT_ELT  = 4'b0011;

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_OP   = 2'b01;
    localparam logic [1:0] ERR_PE   = 2'b10;

    // Config payload occupies bits [29:0] of a config word, in this field order.
    typedef struct packed {
        logic [3:0] layer_type;
        logic       pool;
        logic       relu;
        logic [3:0] in_seg;
        logic [3:0] out_seg;
        logic [7:0] in_w;
        logic [7:0] out_w;
    } cfg_t;

    function automatic int op_lsb(int inst_w);
        return inst_w - TYPE_W - OP_W;
    endfunction

    function automatic int id_lsb(int inst_w, int buf_id_w);
        return op_lsb(inst_w) - buf_id_w;
    endfunction

    function automatic logic ld_op_legal(logic [3:0] op);
        return (op == RD_OP_IMG) || (op == RD_OP_WGT) || (op == RD_OP_BIAS) ||
               (op == RD_OP_SCALE) || (op == RD_OP_POOL) || (op == RD_OP_TBL);
    endfunction

    function automatic logic sv_op_legal(logic [3:0] op);
        return (op == WR_OP_IMG) || (op == WR_OP_RES0) || (op == WR_OP_RES1) ||
               (op == WR_OP_RES2) || (op == WR_OP_RES3);
    endfunction

endpackage

// File: rtl/ins_dispatch_fifo.sv
// Per-unit instruction queue: storage-backed head with valid/ready output, full/empty flags.
module ins_fifo #(
    parameter int W     = 64,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    output logic         full,
    output logic         empty,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          do_push;
    logic          do_pop;

    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == '0);
    assign out_valid = !empty;
    assign out_data  = mem[rd_ptr];
    assign do_push   = push && !full;
    assign do_pop    = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ins_dispatch.sv
// Instruction dispatcher: decodes, checks and routes words to load/calc/save queues,
// and owns the layer config register behind a drain barrier.
module ins_dispatch
    import ins_dispatch_pkg::*;
#(
    parameter int INST_W   = 64,
    parameter int ADDR_W   = 32,
    parameter int BUF_ID_W = 6,
    parameter int PE_NUM   = 64,
    parameter int Q_DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ins_valid,
    output logic              ins_ready,
    input  logic [INST_W-1:0] ins,
    output logic              ld_valid,
    input  logic              ld_ready,
    output logic [INST_W-1:0] ld_ins,
    output logic              ca_valid,
    input  logic              ca_ready,
    output logic [INST_W-1:0] ca_ins,
    output logic              sv_valid,
    input  logic              sv_ready,
    output logic [INST_W-1:0] sv_ins,
    input  logic              ld_idle,
    input  logic              ca_idle,
    input  logic              sv_idle,
    output logic [3:0]        cfg_layer_type,
    output logic              cfg_pool,
    output logic              cfg_relu,
    output logic [3:0]        cfg_in_seg,
    output logic [3:0]        cfg_out_seg,
    output logic [7:0]        cfg_in_w,
    output logic [7:0]        cfg_out_w,
    output logic              cfg_update,
    output logic              err,
    output logic [1:0]        err_code,
    input  logic              err_clr
);
    localparam int OP_LSB = op_lsb(INST_W);
    localparam int ID_LSB = id_lsb(INST_W, BUF_ID_W);

    state_e              state;
    state_e              state_nx;
    ins_type_e           ty;
    logic [OP_W-1:0]     op;
    logic [BUF_ID_W-1:0] pe_id;
    logic                pe_ok;
    logic                legal;
    logic                tgt_full;
    logic                run_fire;
    logic                drained;
    logic                ld_full, ca_full, sv_full;
    logic                ld_empty, ca_empty, sv_empty;
    cfg_t                cfg_cur;
    cfg_t                cfg_pend;

    assign ty    = ins_type_e'(ins[INST_W-1 -: TYPE_W]);
    assign op    = ins[OP_LSB +: OP_W];
    assign pe_id = ins[ID_LSB +: BUF_ID_W];
    assign pe_ok = {{(32-BUF_ID_W){1'b0}}, pe_id} < 32'(PE_NUM);

    always_comb begin
        legal    = 1'b1;
        tgt_full = 1'b0;
        case (ty)
            TY_LOAD: begin legal = ld_op_legal(op); tgt_full = ld_full; end
            TY_CALC: begin legal = pe_ok;           tgt_full = ca_full; end
            TY_SAVE: begin legal = sv_op_legal(op); tgt_full = sv_full; end
            default: begin legal = 1'b1;            tgt_full = 1'b0;    end
        endcase
    end

    // Illegal words still need a free slot in the queue they name, so they stall like legal ones.
    assign ins_ready = (state == S_RUN) && !tgt_full;
    assign run_fire  = ins_valid && ins_ready;
    assign drained   = ld_empty && ca_empty && sv_empty && ld_idle && ca_idle && sv_idle;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_RUN;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_RUN: begin
                if (run_fire) begin
                    if (!legal)            state_nx = S_ERR;
                    else if (ty == TY_CFG) state_nx = S_DRAIN;
                end
            end
            S_DRAIN: if (drained) state_nx = S_RUN;
            S_ERR:   if (err_clr) state_nx = S_RUN;
            default: state_nx = S_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (run_fire && ty == TY_CFG) cfg_pend <= cfg_t'(ins[CFG_W-1:0]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_cur    <= '0;
            cfg_update <= 1'b0;
            err        <= 1'b0;
            err_code   <= ERR_NONE;
        end else begin
            cfg_update <= 1'b0;
            if (state == S_DRAIN && drained) begin
                cfg_cur    <= cfg_pend;
                cfg_update <= 1'b1;
            end
            if (run_fire && !legal) begin
                err      <= 1'b1;
                err_code <= (ty == TY_CALC) ? ERR_PE : ERR_OP;
            end else if (state == S_ERR && err_clr) begin
                err      <= 1'b0;
                err_code <= ERR_NONE;
            end
        end
    end

    assign cfg_layer_type = cfg_cur.layer_type;
    assign cfg_pool       = cfg_cur.pool;
    assign cfg_relu       = cfg_cur.relu;
    assign cfg_in_seg     = cfg_cur.in_seg;
    assign cfg_out_seg    = cfg_cur.out_seg;
    assign cfg_in_w       = cfg_cur.in_w;
    assign cfg_out_w      = cfg_cur.out_w;

    ins_fifo #(.W(INST_W), .DEPTH(Q_DEPTH)) u_ld_q (
        .clk(clk), .rst_n(rst_n),
        .push(run_fire && legal && ty == TY_LOAD), .push_data(ins),
        .full(ld_full), .empty(ld_empty),
        .out_valid(ld_valid), .out_ready(ld_ready), .out_data(ld_ins)
    );

    ins_fifo #(.W(INST_W), .DEPTH(Q_DEPTH)) u_ca_q (
        .clk(clk), .rst_n(rst_n),
        .push(run_fire && legal && ty == TY_CALC), .push_data(ins),
        .full(ca_full), .empty(ca_empty),
        .out_valid(ca_valid), .out_ready(ca_ready), .out_data(ca_ins)
    );

    ins_fifo #(.W(INST_W), .DEPTH(Q_DEPTH)) u_sv_q (
        .clk(clk), .rst_n(rst_n),
        .push(run_fire && legal && ty == TY_SAVE), .push_data(ins),
        .full(sv_full), .empty(sv_empty),
        .out_valid(sv_valid), .out_ready(sv_ready), .out_data(sv_ins)
    );

endmodule

// File: tb/tb_ins_dispatch.sv
// Directed bench for ins_dispatch; a second instance with PE_NUM = 32 shares the stimulus
// to exercise the pe_id range check.
module tb_ins_dispatch;
    import ins_dispatch_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ins_valid;
    logic [63:0] ins;
    logic        ld_ready, ca_ready, sv_ready;
    logic        ld_idle, ca_idle, sv_idle;
    logic        err_clr;

    logic        ins_ready, ld_valid, ca_valid, sv_valid;
    logic [63:0] ld_ins, ca_ins, sv_ins;
    logic [3:0]  cfg_layer_type, cfg_in_seg, cfg_out_seg;
    logic        cfg_pool, cfg_relu, cfg_update, err;
    logic [7:0]  cfg_in_w, cfg_out_w;
    logic [1:0]  err_code;

    logic        b_ins_ready, b_ld_valid, b_ca_valid, b_sv_valid;
    logic [63:0] b_ld_ins, b_ca_ins, b_sv_ins;
    logic [3:0]  b_cfg_layer_type, b_cfg_in_seg, b_cfg_out_seg;
    logic        b_cfg_pool, b_cfg_relu, b_cfg_update, b_err;
    logic [7:0]  b_cfg_in_w, b_cfg_out_w;
    logic [1:0]  b_err_code;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    ins_dispatch #(.PE_NUM(64)) u_dut (
        .clk(clk), .rst_n(rst_n), .ins_valid(ins_valid), .ins_ready(ins_ready), .ins(ins),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_ins(ld_ins),
        .ca_valid(ca_valid), .ca_ready(ca_ready), .ca_ins(ca_ins),
        .sv_valid(sv_valid), .sv_ready(sv_ready), .sv_ins(sv_ins),
        .ld_idle(ld_idle), .ca_idle(ca_idle), .sv_idle(sv_idle),
        .cfg_layer_type(cfg_layer_type), .cfg_pool(cfg_pool), .cfg_relu(cfg_relu),
        .cfg_in_seg(cfg_in_seg), .cfg_out_seg(cfg_out_seg),
        .cfg_in_w(cfg_in_w), .cfg_out_w(cfg_out_w), .cfg_update(cfg_update),
        .err(err), .err_code(err_code), .err_clr(err_clr)
    );

    ins_dispatch #(.PE_NUM(32)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .ins_valid(ins_valid), .ins_ready(b_ins_ready), .ins(ins),
        .ld_valid(b_ld_valid), .ld_ready(ld_ready), .ld_ins(b_ld_ins),
        .ca_valid(b_ca_valid), .ca_ready(ca_ready), .ca_ins(b_ca_ins),
        .sv_valid(b_sv_valid), .sv_ready(sv_ready), .sv_ins(b_sv_ins),
        .ld_idle(ld_idle), .ca_idle(ca_idle), .sv_idle(sv_idle),
        .cfg_layer_type(b_cfg_layer_type), .cfg_pool(b_cfg_pool), .cfg_relu(b_cfg_relu),
        .cfg_in_seg(b_cfg_in_seg), .cfg_out_seg(b_cfg_out_seg),
        .cfg_in_w(b_cfg_in_w), .cfg_out_w(b_cfg_out_w), .cfg_update(b_cfg_update),
        .err(b_err), .err_code(b_err_code), .err_clr(err_clr)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    localparam logic [63:0] LD_W   = 64'h0010_0020_1000_0000;
    localparam logic [63:0] LD_BAD = 64'h2000_0000_0000_0001;
    localparam logic [63:0] SV_W   = 64'hA400_0000_0000_0055;
    localparam logic [63:0] SV_BAD = 64'h8400_0000_0000_0007;
    localparam logic [63:0] CA_PE40 = 64'h4280_0000_0000_0000;
    localparam logic [63:0] CFG_W1 = 64'hC000_0000_0935_1C0E;

    logic [63:0] cw [5];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 5; i++) cw[i] = 64'h4000_0000_0000_0100 + 64'(i);
        rst_n = 1'b0; ins_valid = 1'b0; ins = '0; err_clr = 1'b0;
        ld_ready = 1'b0; ca_ready = 1'b0; sv_ready = 1'b0;
        ld_idle = 1'b1; ca_idle = 1'b1; sv_idle = 1'b1;
        step(); step();

        // Reset state
        chk("rst_ld_valid", ld_valid, 0);
        chk("rst_ca_valid", ca_valid, 0);
        chk("rst_sv_valid", sv_valid, 0);
        chk("rst_err", {err_code, err}, 0);
        chk("rst_cfg", {cfg_layer_type, cfg_pool, cfg_relu, cfg_in_seg, cfg_out_seg, cfg_in_w, cfg_out_w, cfg_update}, 0);
        rst_n = 1'b1;
        step();

        // Single load, 1-cycle latency to unit
        ins = LD_W; ins_valid = 1'b1; ld_ready = 1'b1; #1;
        chk("ld_ready_in", ins_ready, 1);
        step();
        ins_valid = 1'b0;
        chk("ld_valid_1", ld_valid, 1);
        chk("ld_word", ld_ins, LD_W);
        chk("ld_other_valid", {ca_valid, sv_valid}, 0);
        step();
        chk("ld_popped", ld_valid, 0);
        ld_ready = 1'b0;

        // Five calcs into a depth-4 queue with the unit stalled
        for (int i = 0; i < 4; i++) begin
            ins = cw[i]; ins_valid = 1'b1; #1;
            chk("ca_fill_ready", ins_ready, 1);
            step();
        end
        ins = cw[4]; #1;
        chk("ca_full_ready", ins_ready, 0);
        step();
        chk("ca_full_hold", ins_ready, 0);
        chk("ca_head_stable", ca_ins, cw[0]);
        ins_valid = 1'b0; ca_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("ca_out_valid", ca_valid, 1);
            chk("ca_out_word", ca_ins, cw[i]);
            step();
        end
        chk("ca_drained", ca_valid, 0);
        ins = cw[4]; ins_valid = 1'b1; #1;
        chk("ca_5th_ready", ins_ready, 1);
        step();
        ins_valid = 1'b0;
        chk("ca_5th_word", ca_ins, cw[4]);
        step();
        chk("ca_5th_popped", ca_valid, 0);
        ca_ready = 1'b0;

        // Config barrier held off by a busy load unit
        ld_idle = 1'b0;
        ins = CFG_W1; ins_valid = 1'b1; #1;
        chk("cfg_accept", ins_ready, 1);
        step();
        ins = LD_W; #1;
        chk("drain_ready", ins_ready, 0);
        step();
        chk("drain_ready_2", ins_ready, 0);
        chk("drain_cfg_same", {cfg_update, cfg_in_w}, 0);
        ins_valid = 1'b0; ld_idle = 1'b1;
        step();
        chk("cfg_update_pulse", cfg_update, 1);
        chk("cfg_in_w", cfg_in_w, 28);
        chk("cfg_out_w", cfg_out_w, 14);
        chk("cfg_relu_pool", {cfg_relu, cfg_pool}, 2'b10);
        chk("cfg_layer", cfg_layer_type, LT_POOL);
        chk("cfg_segs", {cfg_in_seg, cfg_out_seg}, 8'h35);
        step();
        chk("cfg_update_once", cfg_update, 0);
        chk("cfg_hold", cfg_in_w, 28);

        // Illegal load opcode
        ins = LD_BAD; ins_valid = 1'b1; #1;
        chk("bad_ld_ready", ins_ready, 1);
        step();
        ins = LD_W; #1;
        chk("bad_ld_err", {err, err_code}, {1'b1, ERR_OP});
        chk("bad_ld_not_fwd", ld_valid, 0);
        chk("err_ready", ins_ready, 0);
        step();
        chk("err_sticky", {err, ins_ready}, 2'b10);
        ins_valid = 1'b0; err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("err_cleared", {err, err_code}, 0);
        ins = LD_W; ins_valid = 1'b1; #1;
        chk("resume_ready", ins_ready, 1);
        step();
        ins_valid = 1'b0;
        chk("resume_ld", ld_ins, LD_W);
        ld_ready = 1'b1;
        step();
        ld_ready = 1'b0;

        // Legal save forwarded, illegal save flagged
        ins = SV_W; ins_valid = 1'b1; sv_ready = 1'b1;
        step();
        ins_valid = 1'b0;
        chk("sv_fwd", {sv_valid, sv_ins}, {1'b1, SV_W});
        step();
        ins = SV_BAD; ins_valid = 1'b1;
        step();
        ins_valid = 1'b0;
        chk("bad_sv_err", {err, err_code, sv_valid}, {1'b1, ERR_OP, 1'b0});
        err_clr = 1'b1;
        step();
        err_clr = 1'b0; sv_ready = 1'b0;

        // pe_id 40: legal at PE_NUM 64, illegal at PE_NUM 32
        ins = CA_PE40; ins_valid = 1'b1; #1;
        chk("pe40_ready", {ins_ready, b_ins_ready}, 2'b11);
        step();
        ins_valid = 1'b0;
        chk("pe40_fwd64", {ca_valid, ca_ins}, {1'b1, CA_PE40});
        chk("pe40_ok64", err, 0);
        chk("pe40_err32", {b_err, b_err_code}, {1'b1, ERR_PE});
        chk("pe40_nofwd32", b_ca_valid, 0);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("pe40_clr32", b_err, 0);

        // Reset with queued loads and a pending config
        for (int i = 0; i < 3; i++) begin
            ins = 64'h0000_0000_0000_0A00 + 64'(i); ins_valid = 1'b1;
            step();
        end
        ld_idle = 1'b0;
        ins = 64'hC000_0000_0000_0000; ins_valid = 1'b1;
        step();
        ins_valid = 1'b0;
        chk("pre_rst_drain", {ins_ready, ld_valid}, 2'b01);
        rst_n = 1'b0; #1;
        chk("rst_mid_valids", {ld_valid, ca_valid, sv_valid}, 0);
        chk("rst_mid_cfg", {cfg_in_w, cfg_relu, cfg_layer_type}, 0);
        step();
        rst_n = 1'b1; ld_idle = 1'b1;
        step();
        ins = 64'h0100_0000_0000_0BEE; ins_valid = 1'b1; #1;
        chk("post_rst_ready", ins_ready, 1);
        step();
        ins_valid = 1'b0;
        chk("post_rst_word", {ld_valid, ld_ins}, {1'b1, 64'h0100_0000_0000_0BEE});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
